// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared defaults, state encoding and sizing helper for the slice sequencer
package rca_pkg;

    localparam int RCA_DATA_W  = 64;
    localparam int RCA_SLICE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rca_state_t;

    // A single-slice configuration still needs a one-bit index register.
    function automatic int idx_width(input int nslices);
        return (nslices > 1) ? $clog2(nslices) : 1;
    endfunction

endpackage

// File: rtl/rca_slice_sequencer_if.sv
// rtl/rca_slice_sequencer_if.sv - operand/result handshake bundle for the slice sequencer
interface rca_slice_sequencer_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              c_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              c_out;
    logic              ovf;
    logic              busy;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, busy
    );
endinterface

// File: rtl/rca_slice_sequencer_slice_adder.sv
// rtl/rca_slice_sequencer_slice_adder.sv - combinational ripple-carry slice shared by every slice step
module slice_adder #(
    parameter int SLICE_W = 16
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cy,
    output logic               msb_cin
);
    logic carry;

    always_comb begin
        s       = '0;
        msb_cin = 1'b0;
        carry   = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            if (i == SLICE_W - 1) begin
                msb_cin = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cy = carry;
    end
endmodule

// File: rtl/rca_slice_sequencer.sv
// rtl/rca_slice_sequencer.sv - multi-cycle adder stepping one ripple slice per clock, LSB slice first
module rca_slice_sequencer
    import rca_pkg::*;
#(
    parameter int DATA_W  = RCA_DATA_W,
    parameter int SLICE_W = RCA_SLICE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    rca_slice_sequencer_if.slave bus
);
    localparam int NSLICES = DATA_W / SLICE_W;
    localparam int IDX_W   = idx_width(NSLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    rca_state_t        state, state_nx;
    logic [IDX_W-1:0]  idx_q;
    logic              carry_q;
    logic [DATA_W-1:0] a_q, b_q, sum_q;
    logic              c_out_q, ovf_q;

    logic [SLICE_W-1:0] a_sl [NSLICES];
    logic [SLICE_W-1:0] b_sl [NSLICES];
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cy, slice_msb_cin;

    for (genvar gi = 0; gi < NSLICES; gi++) begin : g_slice_mux
        assign a_sl[gi] = a_q[gi*SLICE_W +: SLICE_W];
        assign b_sl[gi] = b_q[gi*SLICE_W +: SLICE_W];
    end

    slice_adder #(.SLICE_W(SLICE_W)) u_slice (
        .a       (a_sl[idx_q]),
        .b       (b_sl[idx_q]),
        .cin     (carry_q),
        .s       (slice_s),
        .cy      (slice_cy),
        .msb_cin (slice_msb_cin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (bus.in_valid)      state_nx = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_nx = ST_DONE;
            ST_DONE: if (bus.out_ready)     state_nx = ST_IDLE;
            default:                        state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.c_in;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        c_out_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NSLICES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_q[i*SLICE_W +: SLICE_W] <= slice_s;
                        end
                    end
                    carry_q <= slice_cy;
                    // The last slice's internal top-bit carry is the carry into bit DATA_W-1.
                    if (idx_q == LAST_IDX) begin
                        c_out_q <= slice_cy;
                        ovf_q   <= slice_cy ^ slice_msb_cin;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// tb/tb_rca_slice_sequencer.sv - scoreboard bench for the slice-sequenced 64-bit adder
module tb_rca_slice_sequencer;
    localparam int DATA_W  = 64;
    localparam int SLICE_W = 16;
    localparam int NSLICES = DATA_W / SLICE_W;

    typedef struct {
        logic [DATA_W-1:0] sum;
        logic              c;
        logic              v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic rand_ready = 1'b0;

    rca_slice_sequencer_if #(.DATA_W(DATA_W)) bus ();

    rca_slice_sequencer #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv, input logic ci);
        exp_t e;
        logic [DATA_W:0] full;
        full  = {1'b0, av} + {1'b0, bv} + {{DATA_W{1'b0}}, ci};
        e.sum = full[DATA_W-1:0];
        e.c   = full[DATA_W];
        e.v   = (av[DATA_W-1] == bv[DATA_W-1]) && (full[DATA_W-1] != av[DATA_W-1]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a result transfers on the edge after a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sum",   bus.sum,          e.sum);
                chk("c_out", 64'(bus.c_out),   64'(e.c));
                chk("ovf",   64'(bus.ovf),     64'(e.v));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv, input logic ci);
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
        end else begin
            bus.in_valid = 1'b1;
            bus.a        = av;
            bus.b        = bv;
            bus.c_in     = ci;
            sb_q.push_back(model(av, bv, ci));
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 1000 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] ra, rb;
        int lat;
        exp_t e;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_sum",       bus.sum,            64'd0);
        chk("rst_c_out",     64'(bus.c_out),     64'd0);
        chk("rst_ovf",       64'(bus.ovf),       64'd0);

        // Latency: out_valid after NSLICES edges past the acceptance edge.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(NSLICES));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        send(64'h6A, 64'h4, 1'b0);
        send(64'hF, 64'hF, 1'b1);
        send(64'h508B_BE03_01D2_D287, 64'hDF18_1EA7_70DB_8BB5, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        drain();

        // Backpressure with a second request held during DONE.
        bus.out_ready = 1'b0;
        send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        e = model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk("bp_valid_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b1;
        bus.a        = 64'h1111_2222_3333_4444;
        bus.b        = 64'h5555_6666_7777_8888;
        bus.c_in     = 1'b0;
        sb_q.push_back(model(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_sum",       bus.sum,            e.sum);
            chk("bp_c_out",     64'(bus.c_out),     64'(e.c));
            chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_second_accepted", 64'(bus.busy), 64'd1);
        drain();

        // Reset while idx==2 discards the in-flight operation.
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy",      64'(bus.busy),      64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid) lat = 1;
        end
        chk("midrst_no_result", 64'(lat), 64'd0);
        send(64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        drain();

        // Randomized operands with random consumer backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            ra = {32'($urandom), 32'($urandom)};
            rb = {32'($urandom), 32'($urandom)};
            if (n % 7 == 0) rb = ~ra;
            if (n % 11 == 0) ra = 64'h7FFF_FFFF_FFFF_FFFF;
            send(ra, rb, 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rca_slice_sequencer.md
Name: rca_slice_sequencer

Overview:
Multi-cycle 64-bit adder controller. It accepts one operand pair through a valid/ready handshake and sequences a single narrow ripple-carry slice across the operands, least-significant slice first, one slice per clock. The carry is held in a register between slices. The full sum, carry-out and signed overflow are presented through an output valid/ready handshake. The block is a drop-in, area-reduced alternative to the flat 64-bit RCA in the Lab 3 datapath.

Parameters:
DATA_W, 64, operand/sum width; must be an integer multiple of SLICE_W.
SLICE_W, 16, width of the shared combinational slice adder.
NSLICES, DATA_W/SLICE_W (local, derived), number of RUN cycles per operation.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  operand pair presented.
in_ready  output  1  block can accept; high only in IDLE.
a  input  DATA_W  operand A.
b  input  DATA_W  operand B.
c_in  input  1  carry-in to slice 0.
out_valid  output  1  result held and valid.
out_ready  input  1  consumer accepts result.
sum  output  DATA_W  registered sum.
c_out  output  1  carry out of MSB.
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, any state): state=IDLE; idx, carry, a/b regs, sum, c_out, ovf all 0; out_valid=0, busy=0, in_ready=1 once rst deasserts.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On a clock edge with in_valid=1, latch a, b; carry<=c_in; idx<=0; clear sum/c_out/ovf; go to RUN.
  - RUN: in_ready=0, busy=1. Each edge computes {cy, s} = a[idx slice] + b[idx slice] + carry.
    - sum[idx slice]<=s; carry<=cy; idx<=idx+1.
    - On idx==NSLICES-1: c_out<=cy; ovf<=cy XOR (carry into bit DATA_W-1, taken from the slice's internal MSB carry); go to DONE.
  - DONE: out_valid=1. sum/c_out/ovf are stable. On an edge with out_ready=1, go to IDLE and drop out_valid. With out_ready=0, hold indefinitely.
- Latency: acceptance edge E → out_valid high after edge E+NSLICES (4 for the defaults). Minimum issue interval is NSLICES+2 cycles; no acceptance in DONE (in_ready=0).
- in_valid while not IDLE is ignored; operands are not re-sampled.
- out_ready while not DONE is ignored.
- SLICE_W==DATA_W: RUN lasts exactly 1 cycle.
- idx width is clog2(NSLICES), minimum 1 bit. idx never wraps past NSLICES-1.
- rst asserted mid-RUN or in DONE: the in-flight result is discarded and the block returns to IDLE immediately. No partial result is ever flagged valid.
- All outputs are registered; no combinational path from inputs to outputs other than in_ready/out_valid, which decode state.

Decomposition:
- Shared package rca_pkg: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2), DATA_W/SLICE_W defaults.
- Sub-module slice_adder (combinational, SLICE_W-bit ripple carry): outputs s, cy, and msb_cin (carry into its top bit, used for ovf). One instance, shared across all slices via idx-driven muxes.

Test Plan:
- a=FFFFFFFFFFFFFFFF, b=FFFFFFFFFFFFFFFF, c_in=0 → sum=FFFFFFFFFFFFFFFE, c_out=1, ovf=0. out_valid rises exactly 4 edges after acceptance.
- Same operands, c_in=1 → sum=FFFFFFFFFFFFFFFF, c_out=1, ovf=0. Also a=6A, b=4, c_in=0 → sum=6E, c_out=0. Also a=F, b=F, c_in=1 → sum=1F.
- a=508BBE0301D2D287, b=DF181EA770DB8BB5, c_in=0 → sum=2FA3DCAA72AE5E3C, c_out=1, ovf=0. This checks inter-slice carry propagation.
- a=7FFFFFFFFFFFFFFF, b=1, c_in=0 → sum=8000000000000000, c_out=0, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → sum/c_out stable, in_ready=0, a second in_valid is ignored. Raise out_ready → IDLE next edge, then the second pair is accepted.
- Pulse rst during RUN (idx=2) → out_valid stays 0, busy=0 and in_ready=1 after rst drops. A following operation returns the correct result.
